// File: rtl/image_op_sequencer.sv
// ---------------------------------------------------------------------------
// image_op_sequencer
//   Frame-level controller for the pixel-arithmetic datapath. Walks the
//   source image in raster order. For each pixel it reads operand A (and
//   operand B for ADD/SUB), issues one instruction word to the datapath,
//   waits for completion, and writes the result to the destination buffer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, op, imm    host command (sampled only in IDLE)
//   busy, done, error host status (done = 1-cycle pulse, error = sticky)
//   rd_en_a/b, rd_addr, rd_data_a/b     source buffer read port (1-cycle latency)
//   proc_valid, proc_op, proc_a, proc_b datapath issue
//   proc_done, proc_result              datapath completion
//   wr_en, wr_addr, wr_data, wr_ready   destination write handshake
// ---------------------------------------------------------------------------
module image_op_sequencer #(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int PIX_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [PIX_W-1:0]  imm,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_en_a,
    output logic              rd_en_b,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data_a,
    input  logic [PIX_W-1:0]  rd_data_b,
    output logic              proc_valid,
    output logic [1:0]        proc_op,
    output logic [PIX_W-1:0]  proc_a,
    output logic [PIX_W-1:0]  proc_b,
    input  logic              proc_done,
    input  logic [PIX_W-1:0]  proc_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    input  logic              wr_ready
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPTURE, S_ISSUE, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t            state, state_n;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     cnt;
    logic [1:0]        op_q;
    logic [PIX_W-1:0]  imm_q;
    logic [PIX_W-1:0]  cap_a, cap_b;
    logic [1:0]        hold_op;
    logic [PIX_W-1:0]  hold_a, hold_b;
    logic [PIX_W-1:0]  wr_data_q;
    logic              error_q;

    logic last_x, last_y, cnt_max, two_op;

    assign last_x  = (x == XW'(IMG_W - 1));
    assign last_y  = (y == YW'(IMG_H - 1));
    assign cnt_max = (cnt == CW'(TIMEOUT - 1));
    // ADD (0) and SUB (2) are the only ops that use source B
    assign two_op  = ~op_q[0];

    assign rd_addr = addr;
    assign wr_addr = addr;
    assign wr_data = wr_data_q;
    assign error   = error_q;

    // The issue word is presented straight from the capture registers during
    // ISSUE, then held from a shadow copy so the datapath sees stable values
    // until the next ISSUE even though CAPTURE of the next pixel comes first.
    assign proc_op = (state == S_ISSUE) ? op_q  : hold_op;
    assign proc_a  = (state == S_ISSUE) ? cap_a : hold_a;
    assign proc_b  = (state == S_ISSUE) ? cap_b : hold_b;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        rd_en_a    = 1'b0;
        rd_en_b    = 1'b0;
        proc_valid = 1'b0;
        wr_en      = 1'b0;
        case (state)
            S_IDLE:    if (start) state_n = S_READ;
            S_READ: begin
                rd_en_a = 1'b1;
                rd_en_b = two_op;
                state_n = S_CAPTURE;
            end
            S_CAPTURE: state_n = S_ISSUE;
            S_ISSUE: begin
                proc_valid = 1'b1;
                state_n    = S_WAIT;
            end
            S_WAIT: begin
                if (proc_done)    state_n = S_WRITE;
                else if (cnt_max) state_n = S_IDLE;
            end
            S_WRITE: begin
                wr_en = 1'b1;
                if (wr_ready) state_n = (last_x && last_y) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            cnt       <= '0;
            op_q      <= '0;
            imm_q     <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            hold_op   <= '0;
            hold_a    <= '0;
            hold_b    <= '0;
            wr_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_q    <= op;
                    imm_q   <= imm;
                    error_q <= 1'b0;
                    x       <= '0;
                    y       <= '0;
                    addr    <= '0;
                end
                S_CAPTURE: begin
                    cap_a <= rd_data_a;
                    cap_b <= two_op ? rd_data_b : imm_q;
                end
                S_ISSUE: begin
                    hold_op <= op_q;
                    hold_a  <= cap_a;
                    hold_b  <= cap_b;
                    cnt     <= '0;
                end
                S_WAIT: begin
                    if (proc_done)    wr_data_q <= proc_result;
                    else if (cnt_max) error_q   <= 1'b1;
                    else              cnt       <= cnt + CW'(1);
                end
                S_WRITE: if (wr_ready && !(last_x && last_y)) begin
                    // raster address kept incrementally: row wrap is just +1
                    addr <= addr + ADDR_W'(1);
                    if (last_x) begin
                        x <= '0;
                        y <= y + YW'(1);
                    end else begin
                        x <= x + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_image_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_image_op_sequencer
//   Self-checking bench for image_op_sequencer on a 4x2 image. Source
//   buffers, datapath and destination are behavioural models; a negedge
//   monitor scoreboards reads, issues and writes against the frame rules.
// ---------------------------------------------------------------------------
module tb_image_op_sequencer;

    localparam int W = 4, H = 2, N = W * H, TMO = 64;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] op;
    logic [7:0] imm;
    logic       busy, done, error, rd_en_a, rd_en_b;
    logic [7:0] rd_addr, rd_data_a, rd_data_b;
    logic       proc_valid;
    logic [1:0] proc_op;
    logic [7:0] proc_a, proc_b;
    logic       proc_done;
    logic [7:0] proc_result;
    logic       wr_en, wr_ready;
    logic [7:0] wr_addr, wr_data;

    image_op_sequencer #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .ADDR_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .imm(imm),
        .busy(busy), .done(done), .error(error),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_addr(rd_addr),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .proc_valid(proc_valid), .proc_op(proc_op), .proc_a(proc_a), .proc_b(proc_b),
        .proc_done(proc_done), .proc_result(proc_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment models ----------------
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] stall_addr = 8'hFF;   // pixel whose issue never completes
    logic [7:0] hold_addr  = 8'hFF;   // pixel whose write is back-pressured
    int         hold_n     = 0;
    int         hold_used  = 0;
    logic [1:0] exp_op;
    logic [7:0] exp_imm;
    logic       clr = 1'b0;

    function automatic logic [7:0] dp(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        return o[1] ? a - b : a + b;
    endfunction

    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem_a[rd_addr];
        if (rd_en_b) rd_data_b <= mem_b[rd_addr];
        if (rst) proc_done <= 1'b0;
        else     proc_done <= proc_valid && (rd_addr != stall_addr);
        proc_result <= dp(proc_op, proc_a, proc_b);
        if (start) hold_used <= 0;
        else if (wr_en && wr_addr == hold_addr && hold_used < hold_n) hold_used <= hold_used + 1;
    end

    assign wr_ready = !(wr_en && wr_addr == hold_addr && hold_used < hold_n);

    // ---------------- monitor / scoreboard ----------------
    int         wcnt [0:255];
    logic [7:0] wval [0:255];
    int wn, order_bad, rdb_cnt, wen_cnt, iss_idx, iss_bad, done_cnt;
    int done_cyc, start_cyc, err_cyc, stab_err;
    logic pend, err_prev;
    logic [7:0] p_addr, p_data;

    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) begin
                wcnt[i] <= 0;
                wval[i] <= 8'h00;
            end
            wn <= 0; order_bad <= 0; rdb_cnt <= 0; wen_cnt <= 0; iss_idx <= 0;
            iss_bad <= 0; done_cnt <= 0; done_cyc <= 0; start_cyc <= 0;
            err_cyc <= 0; stab_err <= 0; pend <= 1'b0; err_prev <= error;
        end else begin
            if (start && !busy) start_cyc <= cyc;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (error && !err_prev) err_cyc <= cyc;
            err_prev <= error;
            if (rd_en_b) rdb_cnt <= rdb_cnt + 1;
            if (proc_valid) begin
                if (proc_op !== exp_op || proc_a !== mem_a[iss_idx] ||
                    proc_b !== (exp_op[0] ? exp_imm : mem_b[iss_idx]))
                    iss_bad <= iss_bad + 1;
                iss_idx <= iss_idx + 1;
            end
            if (wr_en) wen_cnt <= wen_cnt + 1;
            if (pend && (!wr_en || wr_addr !== p_addr || wr_data !== p_data)) stab_err <= stab_err + 1;
            pend   <= wr_en && !wr_ready;
            p_addr <= wr_addr;
            p_data <= wr_data;
            if (wr_en && wr_ready) begin
                if (wr_addr != 8'(wn)) order_bad <= order_bad + 1;
                wn <= wn + 1;
                wcnt[wr_addr] <= wcnt[wr_addr] + 1;
                wval[wr_addr] <= wr_data;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, error, rd_en_a, rd_en_b, rd_addr, proc_valid, proc_op,
                proc_a, proc_b, wr_en, wr_addr, wr_data};
    endfunction

    task automatic fill(input bit directed);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = directed ? 8'(i) : 8'($urandom);
            mem_b[i] = directed ? 8'd10 : 8'($urandom);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [7:0] im);
        exp_op = o; exp_imm = im;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0; op = o; imm = im; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // waits for done or timeout-abort; optionally pulses a bogus start mid-frame
    task automatic wait_end(input string tag, input int busy_start_at);
        bit ended = 1'b0;
        for (int k = 0; k < 2000 && !ended; k++) begin
            @(negedge clk);
            if (k == busy_start_at)     begin start = 1'b1; op = 2'd3; imm = 8'd77; end
            if (k == busy_start_at + 1) begin start = 1'b0; op = exp_op; imm = exp_imm; end
            if (done || (error && !busy)) ended = 1'b1;
        end
        start = 1'b0;
        chk({tag, " frame_ended"}, 64'(ended), 64'd1);
        @(negedge clk);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic check_frame(input string tag, input int exp_lat, input int hn);
        int bad = 0;
        for (int i = 0; i < N; i++)
            if (wcnt[i] != 1 || wval[i] !== dp(exp_op, mem_a[i], exp_op[0] ? exp_imm : mem_b[i])) bad++;
        chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " done_latency"}, 64'(done_cyc - start_cyc), 64'(exp_lat));
        chk({tag, " error"}, 64'(error), 64'd0);
        chk({tag, " write_data"}, 64'(bad), 64'd0);
        chk({tag, " write_order"}, 64'(order_bad + (wn != N)), 64'd0);
        chk({tag, " rd_b_count"}, 64'(rdb_cnt), exp_op[0] ? 64'd0 : 64'(N));
        chk({tag, " issues"}, 64'(iss_bad + (iss_idx != N)), 64'd0);
        chk({tag, " wr_en_cycles"}, 64'(wen_cnt), 64'(N + hn));
        chk({tag, " wr_stable"}, 64'(stab_err), 64'd0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] imm;
        bit         directed;
        logic [7:0] haddr;
        int         hn;
        int         lat;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int bad;
        tbl[0] = '{2'd0, 8'd0,  1'b1, 8'hFF, 0, 41};   // ADD, A=i, B=10
        tbl[1] = '{2'd3, 8'd3,  1'b1, 8'hFF, 0, 41};   // SUBI imm=3
        tbl[2] = '{2'd0, 8'd0,  1'b1, 8'd2,  4, 45};   // back-pressure on pixel 2
        tbl[3] = '{2'd2, 8'd0,  1'b0, 8'hFF, 0, 41};   // SUB random data
        tbl[4] = '{2'd1, 8'(($urandom)), 1'b0, 8'd5, 2, 43};

        rst = 1'b1; start = 1'b0; op = 2'd0; imm = 8'd0;
        exp_op = 2'd0; exp_imm = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            fill(tbl[v].directed);
            hold_addr = tbl[v].haddr; hold_n = tbl[v].hn;
            launch(tbl[v].op, tbl[v].imm);
            wait_end($sformatf("vec%0d", v), -1);
            check_frame($sformatf("vec%0d", v), tbl[v].lat, tbl[v].hn);
        end
        chk("vec2 pixel2_hold", 64'(wcnt[2]), 64'd1);

        for (int r = 0; r < 6; r++) begin
            int hn_r;
            hn_r = int'($urandom_range(0, 6));
            fill(1'b0);
            hold_addr = 8'($urandom_range(0, N - 1)); hold_n = hn_r;
            launch(2'($urandom_range(0, 3)), 8'($urandom));
            wait_end($sformatf("rand%0d", r), -1);
            check_frame($sformatf("rand%0d", r), 5 * N + 1 + hn_r, hn_r);
        end

        // timeout on pixel 5, then recovery
        fill(1'b1); hold_addr = 8'hFF; hold_n = 0; stall_addr = 8'd5;
        launch(2'd0, 8'd0);
        wait_end("tmo", -1);
        chk("tmo error", 64'(error), 64'd1);
        chk("tmo no_done", 64'(done_cnt), 64'd0);
        chk("tmo abort_cycle", 64'(err_cyc - start_cyc), 64'(5 * 5 + 4 + TMO));
        bad = 0;
        for (int i = 0; i < N; i++) if (wcnt[i] != (i < 5 ? 1 : 0)) bad++;
        chk("tmo partial_writes", 64'(bad), 64'd0);
        stall_addr = 8'hFF;
        launch(2'd0, 8'd0);
        @(negedge clk);
        chk("tmo error_cleared", 64'(error), 64'd0);
        wait_end("tmo_rerun", -1);
        check_frame("tmo_rerun", 41, 0);

        // start while busy is ignored
        fill(1'b0);
        launch(2'd0, 8'd0);
        wait_end("busy_start", 12);
        check_frame("busy_start", 41, 0);

        // reset during the (stalled) write of pixel 3
        fill(1'b1); hold_addr = 8'd3; hold_n = 20;
        launch(2'd0, 8'd0);
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 200 && !hit; k++) begin
                @(negedge clk);
                if (wr_en && wr_addr == 8'd3) hit = 1'b1;
            end
            chk("rst reached_write3", 64'(hit), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst outputs_zero", all_outs(), 64'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst no_done", 64'(done_cnt), 64'd0);
        chk("rst writes", 64'(wn), 64'd3);
        chk("rst idle", 64'(busy), 64'd0);
        hold_addr = 8'hFF; hold_n = 0;
        fill(1'b0);
        launch(2'd2, 8'd0);
        wait_end("rst_rerun", -1);
        check_frame("rst_rerun", 41, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/image_op_sequencer.md
Name: image_op_sequencer

Overview:
- Frame-level controller for the pixel-arithmetic datapath (ADD/ADDI/SUB/SUBI).
- Walks a source image in raster order: reads pixel A and, for the two-operand ops, pixel B from two source buffers.
- Issues one instruction word per pixel to the datapath, waits for its completion handshake, then writes the result into a destination buffer.
- Sits between the host command interface and the datapath/frame buffers; one frame operation runs at a time.

Parameters:
- IMG_W, 16, image width in pixels (≥1)
- IMG_H, 16, image height in pixels (≥1)
- PIX_W, 8, pixel width in bits
- ADDR_W, 8, buffer address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- TIMEOUT, 64, max cycles spent in WAIT_PROC before abort

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame operation; sampled only in IDLE
- op  in  2  opcode: 0=ADD, 1=ADDI, 2=SUB, 3=SUBI
- imm  in  PIX_W  user immediate for ADDI/SUBI
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful frame completion
- error  out  1  sticky timeout flag; cleared by rst or next accepted start
- rd_en_a  out  1  source-A read strobe
- rd_en_b  out  1  source-B read strobe
- rd_addr  out  ADDR_W  shared read address
- rd_data_a  in  PIX_W  source-A data, valid one cycle after rd_en_a
- rd_data_b  in  PIX_W  source-B data, valid one cycle after rd_en_b
- proc_valid  out  1  instruction-word issue strobe
- proc_op  out  2  opcode to datapath
- proc_a  out  PIX_W  operand A
- proc_b  out  PIX_W  operand B, or imm for ADDI/SUBI
- proc_done  in  1  datapath completion, qualifies proc_result
- proc_result  in  PIX_W  datapath result
- wr_en  out  1  destination write request
- wr_addr  out  ADDR_W  destination address
- wr_data  out  PIX_W  destination data
- wr_ready  in  1  destination accepts write this cycle

Behaviour:
- Reset:
  - state=IDLE.
  - x, y, addr, timeout counter cleared.
  - All outputs 0.
  - Reset mid-frame aborts immediately; no further reads or writes; no done pulse.
- Address: addr = y*IMG_W + x, maintained incrementally; it is not recomputed with a multiplier.
- IDLE:
  - On start=1: latch op and imm, clear error, x=y=addr=0, go to READ.
  - start in any other state is ignored.
- READ (1 cycle):
  - rd_en_a=1, rd_addr=addr.
  - rd_en_b=1 only when op is ADD or SUB.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - Register rd_data_a into opA.
  - Register rd_data_b into opB for ADD/SUB; otherwise opB=imm.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - proc_valid=1; proc_op, proc_a, proc_b driven from the latched values.
  - Clear the timeout counter; go to WAIT_PROC.
  - proc_op, proc_a and proc_b hold their values until the next ISSUE.
- WAIT_PROC:
  - proc_done is sampled starting the cycle after ISSUE.
  - On proc_done=1: capture proc_result into wr_data, go to WRITE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without proc_done: set error, go to IDLE with no done pulse. The partially written frame is left as-is.
  - proc_done arriving in any other state is ignored.
- WRITE:
  - wr_en=1; wr_addr=addr and wr_data are held stable until wr_ready=1.
  - On acceptance:
    - If x==IMG_W-1 and y==IMG_H-1 (last pixel): go to DONE.
    - Else if x==IMG_W-1: x=0, y++, addr++, go to READ.
    - Else: x++, addr++, go to READ.
- DONE (1 cycle): done=1, busy=1; next state IDLE.
- Throughput: 5 cycles per pixel minimum (proc_done and wr_ready both immediate), plus 1 DONE cycle.
- Arithmetic (saturation etc.) belongs to the datapath; the sequencer passes data unmodified.
- Degenerate 1x1 image: a single pixel pass, then DONE.

Test Plan:
- IMG_W=4, IMG_H=2, op=ADD, A[i]=i, B[i]=10, model datapath returns A+B with proc_done the cycle after issue, wr_ready=1 -> 8 writes addr 0..7, data 10..17; done pulses exactly 41 cycles after the start-sample cycle; busy low the next cycle.
- op=SUBI, imm=3 -> rd_en_b never asserted; proc_b=3 on every issue; proc_op=3.
- wr_ready held low 4 cycles on pixel 2 -> wr_en, wr_addr=2 and wr_data held stable for 5 cycles; exactly one write per address; done delayed by 4 cycles.
- Datapath never asserts proc_done on pixel 5 -> error=1 after TIMEOUT cycles in WAIT_PROC; state IDLE; done never pulses. A following start clears error and the frame completes.
- start pulsed while busy mid-frame -> ignored; latched op unchanged; addresses continue in sequence.
- rst asserted during WRITE of pixel 3 -> next cycle: all outputs 0, busy=0, no done. A subsequent start restarts at addr 0.
